decision_funct_ctrl: RTL and testbench
======================================

Name: decision_funct_ctrl

Overview:
Sequencer for the SVM decision-function datapath. On start it walks the support vectors 0..NUM_OF_SV-1. For each one it fetches the signed coefficient (alpha_i*y_i) from coefficient memory, accepts that SV's kernel value over a valid/ready stream, and multiply-accumulates the pair. It then adds the bias b and presents the decision value, the class y_class and a cascade "confident" flag through a valid/ready result handshake. It sits between the kernel engine and the next cascade stage.

Parameters:
XLEN_PIXEL, 8, pixel width; derived widths key off it
NUM_OF_SV, 2, number of support vectors per decision (>=1)
DECISION_FUNCT_SIZE, 48, signed accumulator / decision value width
MARGIN, 48'd1024, |decision| threshold for the confident flag

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one decision; sampled only in IDLE
b  in  2*XLEN_PIXEL  signed bias; latched on accepted start
busy  out  1  high in every state except IDLE and DONE
coef_rd_en  out  1  coefficient memory read strobe
coef_addr  out  clog2(NUM_OF_SV) (min 1)  coefficient index
coef_data  in  2*XLEN_PIXEL  signed alpha*y; valid the cycle after coef_rd_en
kernel_valid  in  1  kernel value present
kernel_ready  out  1  controller accepts the kernel value
kernel_in  in  4*XLEN_PIXEL  unsigned kernel value for the current SV
result_valid  out  1  decision result available
result_ready  in  1  downstream consumes the result
decision_value  out  DECISION_FUNCT_SIZE  signed sum(alpha*y*K) + b
y_class  out  1  1 if decision_value >= 0, else 0
confident  out  1  1 if |decision_value| >= MARGIN

Behaviour:
- Reset (asynchronous, any state): state=IDLE, sv_idx=0, accumulator=0. All outputs 0: busy, coef_rd_en, coef_addr, kernel_ready, result_valid, decision_value, y_class, confident.
- IDLE: on start=1, latch b, clear the accumulator, set sv_idx=0, go to FETCH.
- FETCH (1 cycle): coef_rd_en=1, coef_addr=sv_idx. Go to WAIT_K.
- WAIT_K: capture coef_data on entry (the memory holds its output). kernel_ready=1. When kernel_valid=1, latch kernel_in and go to MAC. Otherwise stay; there is no timeout.
- MAC (1 cycle): product = signed({1'b0,kernel}) * signed(coef), which fits in 48 bits signed.
  - acc = sat(acc + sext(product)), saturating to the signed DECISION_FUNCT_SIZE range; no wrap.
  - If sv_idx==NUM_OF_SV-1, go to BIAS. Otherwise sv_idx+1 and go to FETCH.
- BIAS (1 cycle): acc = sat(acc + sext(b)). Register decision_value, y_class and confident from the result. Go to DONE.
- DONE: result_valid=1; decision_value, y_class and confident are stable.
  - On result_ready=1, go to IDLE. result_valid drops the next cycle; the data outputs hold their last values.
- start is ignored outside IDLE. A start and a result_ready in the same DONE cycle do not chain; start must be reasserted in IDLE.
- Latency: with kernel_valid held high, result_valid rises 3*NUM_OF_SV+2 cycles after the start edge. Each kernel_valid stall cycle adds 1.
- Exactly one kernel value is accepted per SV (kernel_valid && kernel_ready). kernel_ready is never high outside WAIT_K.
- confident uses the saturated magnitude; |min| is treated as max.

Decomposition:
- Shared package svm_pkg holds:
  - widths: KERNEL_W=4*XLEN_PIXEL, COEF_W=2*XLEN_PIXEL, ACC_W=DECISION_FUNCT_SIZE
  - state encoding: IDLE, FETCH, WAIT_K, MAC, BIAS, DONE
  - signed saturation limits
- One natural sub-module: sat_add (signed saturating adder, width-parameterised), instantiated for both the MAC and the bias add.
- The FSM and registers stay in the top module.

Test Plan:
1. NUM_OF_SV=2, coef={1,1}, kernel={0x7FFFFFFF,0x00000002}, b=4, kernel_valid tied high -> decision_value=0x80000005, y_class=1, confident=1, result_valid rises at cycle 8 after start.
2. coef={-1,-1}, same kernels, b=4 -> decision_value=-0x7FFFFFFD, y_class=0, confident=1.
3. coef={-32768,-32768}, kernel={0xFFFFFFFF,0xFFFFFFFF}, b=0 -> decision_value saturates to -2^47 with no wrap, y_class=0.
4. coef={1,-1}, kernel={5,5}, b=0 -> decision_value=0, y_class=1, confident=0. Then b=-1 -> y_class=0.
5. Hold kernel_valid low 3 cycles in each WAIT_K, and hold result_ready low 4 cycles in DONE -> same result as scenario 1. kernel_ready is only high in WAIT_K, result_valid and data stay stable while stalled, and IDLE is reached one cycle after result_ready.
6. Pulse rst_n low while in MAC of SV 0 -> all outputs 0 immediately; a fresh start then completes scenario 1 correctly. A start pulsed while busy -> no effect.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared widths, FSM encoding and saturation limits for the SVM decision-function sequencer.
package svm_pkg;

  localparam int XLEN_PIXEL          = 8;
  localparam int NUM_OF_SV           = 2;
  localparam int DECISION_FUNCT_SIZE = 48;

  localparam int KERNEL_W = 4 * XLEN_PIXEL;
  localparam int COEF_W   = 2 * XLEN_PIXEL;
  localparam int ACC_W    = DECISION_FUNCT_SIZE;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] WAIT_K = 3'd2;
  localparam logic [2:0] MAC    = 3'd3;
  localparam logic [2:0] BIAS   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/sat_add.sv
// Signed two-operand adder that clamps to the signed W-bit range instead of wrapping.
module sat_add #(
  parameter int W = 48
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};

  // The two top bits of the sign-extended sum disagree only on overflow.
  always_comb begin
    sum = wide[W-1:0];
    if (wide[W] != wide[W-1]) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/decision_funct_ctrl.sv
// Walks the support vectors, multiply-accumulates coefficient * kernel, adds the bias and
// presents the decision over a valid/ready result handshake.
module decision_funct_ctrl
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL          = svm_pkg::XLEN_PIXEL,
  parameter int NUM_OF_SV           = svm_pkg::NUM_OF_SV,
  parameter int DECISION_FUNCT_SIZE = svm_pkg::DECISION_FUNCT_SIZE,
  parameter logic [DECISION_FUNCT_SIZE-1:0] MARGIN = 48'd1024,
  localparam int KW = 4 * XLEN_PIXEL,
  localparam int CW = 2 * XLEN_PIXEL,
  localparam int AW = DECISION_FUNCT_SIZE,
  localparam int IW = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] b,
  output logic          busy,
  output logic          coef_rd_en,
  output logic [IW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          kernel_valid,
  output logic          kernel_ready,
  input  logic [KW-1:0] kernel_in,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [AW-1:0] decision_value,
  output logic          y_class,
  output logic          confident
);

  // Handshakes: a kernel value transfers on a rising edge where kernel_valid && kernel_ready;
  // a result transfers where result_valid && result_ready. Ready/valid never depend combinationally
  // on the partner's signal.

  localparam logic [AW-1:0] MAX_L = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MIN_L = {1'b1, {(AW-1){1'b0}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OF_SV - 1);

  logic [2:0]    state;
  logic [IW-1:0] sv_idx;
  logic [AW-1:0] acc;
  logic [CW-1:0] b_reg;
  logic [CW-1:0] coef_reg;
  logic [KW-1:0] kernel_reg;

  logic signed [AW-1:0] product;
  logic [AW-1:0]        mac_sum;
  logic [AW-1:0]        bias_sum;
  logic [AW-1:0]        mag;

  // Kernel is unsigned, coefficient signed; the product is known to fit in AW bits.
  assign product = $signed({{(AW-KW){1'b0}}, kernel_reg})
                 * $signed({{(AW-CW){coef_reg[CW-1]}}, coef_reg});

  sat_add #(.W(AW)) u_mac_add (
    .a   (acc),
    .b   (product),
    .sum (mac_sum)
  );

  sat_add #(.W(AW)) u_bias_add (
    .a   (acc),
    .b   ({{(AW-CW){b_reg[CW-1]}}, b_reg}),
    .sum (bias_sum)
  );

  // The saturated minimum has no positive twin; treat its magnitude as the maximum.
  always_comb begin
    mag = bias_sum;
    if (bias_sum[AW-1]) begin
      mag = (bias_sum == MIN_L) ? MAX_L : -bias_sum;
    end
  end

  assign busy         = (state != IDLE) && (state != DONE);
  assign coef_rd_en   = (state == FETCH);
  assign coef_addr    = sv_idx;
  assign kernel_ready = (state == WAIT_K);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sv_idx         <= '0;
      acc            <= '0;
      b_reg          <= '0;
      coef_reg       <= '0;
      kernel_reg     <= '0;
      decision_value <= '0;
      y_class        <= 1'b0;
      confident      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b_reg  <= b;
            acc    <= '0;
            sv_idx <= '0;
            state  <= FETCH;
          end
        end
        FETCH: state <= WAIT_K;
        WAIT_K: begin
          // Coefficient memory holds its output, so sampling it at acceptance is safe.
          if (kernel_valid) begin
            kernel_reg <= kernel_in;
            coef_reg   <= coef_data;
            state      <= MAC;
          end
        end
        MAC: begin
          acc <= mac_sum;
          if (sv_idx == LAST_IDX) begin
            state <= BIAS;
          end else begin
            sv_idx <= sv_idx + 1'b1;
            state  <= FETCH;
          end
        end
        BIAS: begin
          acc            <= bias_sum;
          decision_value <= bias_sum;
          y_class        <= ~bias_sum[AW-1];
          confident      <= (mag >= MARGIN);
          state          <= DONE;
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decision_funct_ctrl.sv
// Randomised bench for decision_funct_ctrl with an arithmetic reference model and per-cycle result checks.
module tb_decision_funct_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] b;
  logic        busy;
  logic        coef_rd_en;
  logic [0:0]  coef_addr;
  logic [15:0] coef_data;
  logic        kernel_valid;
  logic        kernel_ready;
  logic [31:0] kernel_in;
  logic        result_valid;
  logic        result_ready;
  logic [47:0] decision_value;
  logic        y_class;
  logic        confident;

  decision_funct_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .b              (b),
    .busy           (busy),
    .coef_rd_en     (coef_rd_en),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .kernel_valid   (kernel_valid),
    .kernel_ready   (kernel_ready),
    .kernel_in      (kernel_in),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .decision_value (decision_value),
    .y_class        (y_class),
    .confident      (confident)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] coef_mem [2];
  logic [47:0] exp_dec;
  logic        exp_y;
  logic        exp_conf;
  bit          chk_en = 1'b0;

  // coefficient memory: registered read, output held between reads
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) coef_data <= '0;
    else if (coef_rd_en) coef_data <= coef_mem[coef_addr];
  end

  localparam longint MAXV = (longint'(1) <<< 47) - 1;
  localparam longint MINV = -(longint'(1) <<< 47);

  function automatic longint clamp(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint model(input longint c0, input longint c1,
                                   input longint k0, input longint k1, input longint bb);
    longint acc;
    acc = clamp(k0 * c0);
    acc = clamp(acc + k1 * c1);
    acc = clamp(acc + bb);
    return acc;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: result fields every cycle they are presented, and kernel_ready placement
  always @(negedge clk) begin
    if (rst_n && chk_en && result_valid) begin
      check("decision_value", 64'(decision_value), 64'(exp_dec));
      check("y_class", 64'(y_class), 64'(exp_y));
      check("confident", 64'(confident), 64'(exp_conf));
    end
    if (rst_n && kernel_ready)
      check("kready_only_in_wait", 64'({busy, result_valid, coef_rd_en}), 64'(3'b100));
  end

  task automatic run_decision(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [31:0] k0, input logic [31:0] k1,
                              input logic [15:0] bb, input int kstall, input int rstall,
                              input bit busy_start);
    longint m;
    int lat, hs, stall_cnt;
    bit hs_now;
    logic [31:0] kv [2];
    coef_mem[0] = c0;
    coef_mem[1] = c1;
    kv[0] = k0;
    kv[1] = k1;
    b = bb;
    m = model(longint'($signed(c0)), longint'($signed(c1)),
              longint'(k0), longint'(k1), longint'($signed(bb)));
    exp_dec  = m[47:0];
    exp_y    = (m >= 0);
    exp_conf = (((m < 0) ? -m : m) >= 1024);
    chk_en = 1'b1;

    start = 1'b1;
    kernel_in = k0;
    kernel_valid = (kstall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; hs = 0; stall_cnt = 0;
    while (!result_valid && lat < 300) begin
      start = busy_start && (lat == 4);
      if (kernel_ready) begin
        if (stall_cnt < kstall) begin
          kernel_valid = 1'b0;
          stall_cnt++;
        end else begin
          kernel_valid = 1'b1;
        end
      end else begin
        kernel_valid = (kstall == 0);
      end
      hs_now = kernel_valid && kernel_ready;
      @(posedge clk); #1;
      lat++;
      if (hs_now) begin
        hs++;
        stall_cnt = 0;
        if (hs < 2) kernel_in = kv[hs];
      end
    end
    start = 1'b0;
    kernel_valid = 1'b0;
    check("latency", 64'(lat), 64'(8 + 2 * kstall));
    check("kernel_accepts", 64'(hs), 64'd2);

    repeat (rstall) begin
      @(posedge clk); #1;
    end
    check("result_valid_held", 64'(result_valid), 64'd1);

    result_ready = 1'b1;
    start = busy_start;
    @(posedge clk); #1;
    result_ready = 1'b0;
    start = 1'b0;
    check("result_valid_drop", 64'(result_valid), 64'd0);
    check("idle_after_ready", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("no_chain", 64'(busy), 64'd0);
    check("data_hold", 64'(decision_value), 64'(exp_dec));
    chk_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    b = '0;
    kernel_valid = 1'b0;
    kernel_in = '0;
    result_ready = 1'b0;
    coef_mem[0] = '0;
    coef_mem[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, coef_rd_en, coef_addr, kernel_ready, result_valid,
                                y_class, confident}), 64'd0);
    check("reset_decision", 64'(decision_value), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pin the model itself
    check("model_pin_s1", 64'(model(1, 1, 64'h7FFFFFFF, 2, 4)), 64'h80000005);
    check("model_pin_s2", 64'(model(-1, -1, 64'h7FFFFFFF, 2, 4)), 64'(-64'sh7FFFFFFD));
    check("model_pin_s3", 64'(model(-32768, -32768, 64'hFFFFFFFF, 64'hFFFFFFFF, 0)),
          64'(MINV));
    check("model_pin_s4", 64'(model(1, -1, 5, 5, 0)), 64'd0);

    run_decision(16'd1, 16'd1, 32'h7FFFFFFF, 32'd2, 16'd4, 0, 0, 1'b0);
    check("s1_literal", 64'({decision_value, y_class, confident}),
          64'({48'h80000005, 1'b1, 1'b1}));
    run_decision(16'hFFFF, 16'hFFFF, 32'h7FFFFFFF, 32'd2, 16'd4, 0, 1, 1'b1);
    run_decision(16'h8000, 16'h8000, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'd0, 0, 0, 1'b0);
    check("s3_saturated", 64'(decision_value), 64'(48'h800000000000));
    run_decision(16'd1, 16'hFFFF, 32'd5, 32'd5, 16'd0, 0, 0, 1'b0);
    check("s4_zero_class", 64'({y_class, confident}), 64'd2);
    run_decision(16'd1, 16'hFFFF, 32'd5, 32'd5, 16'hFFFF, 0, 0, 1'b0);
    check("s4_neg_class", 64'(y_class), 64'd0);
    run_decision(16'd1, 16'd1, 32'h7FFFFFFF, 32'd2, 16'd4, 3, 4, 1'b1);

    // asynchronous reset in MAC of SV 0
    coef_mem[0] = 16'd1;
    coef_mem[1] = 16'd1;
    start = 1'b1;
    kernel_valid = 1'b1;
    kernel_in = 32'h7FFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    kernel_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({busy, coef_rd_en, coef_addr, kernel_ready, result_valid,
                                       y_class, confident}), 64'd0);
    check("midrun_reset_decision", 64'(decision_value), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_decision(16'd1, 16'd1, 32'h7FFFFFFF, 32'd2, 16'd4, 0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_decision(16'($urandom), 16'($urandom), 32'($urandom), 32'($urandom),
                   16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
